// File: rtl/lsm_pkg.sv
// Shared types and default dimensions for the load/store-multiple sequencer.
package lsm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } lsm_state_e;

   localparam int LSM_NUM_REGS = 8;
   localparam int LSM_DATA_W   = 16;
   localparam int LSM_ADDR_W   = 16;

   // Bits needed to count 0..n selected registers inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit priority encoder; any flags a non-zero input vector.
module lsm_prio_enc #(
   parameter  int NUM_REGS = 8,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic [NUM_REGS-1:0] vec,
   output logic [IDX_W-1:0]    idx,
   output logic                any
);

   // Scan downward so the lowest set bit is the last one to win.
   always_comb begin
      idx = {IDX_W{1'b0}};
      any = 1'b0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         idx = vec[i] ? IDX_W'(i) : idx;
         any = any | vec[i];
      end
   end

endmodule

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: one memory beat per selected register, lowest index first.
// Optional base-register writeback ports are enabled by defining LSM_WRITEBACK_EN.
module lsm_sequencer
   import lsm_pkg::*;
#(
   parameter  int NUM_REGS = LSM_NUM_REGS,
   parameter  int DATA_W   = LSM_DATA_W,
   parameter  int ADDR_W   = LSM_ADDR_W,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic                is_store,
   input  logic [NUM_REGS-1:0] mask,
   input  logic [ADDR_W-1:0]   base_addr,
   output logic                busy,
   output logic                done,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [IDX_W-1:0]    rf_raddr,
   input  logic [DATA_W-1:0]   rf_rdata,
   output logic                rf_we,
   output logic [IDX_W-1:0]    rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata
`ifdef LSM_WRITEBACK_EN
   ,
   output logic                wb_we,
   output logic [ADDR_W-1:0]   wb_addr
`endif
);

   localparam int CNT_W = cnt_width(NUM_REGS);

   lsm_state_e          state_r;
   lsm_state_e          next_s;
   logic [NUM_REGS-1:0] rem_mask_r;
   logic [NUM_REGS-1:0] clr_mask_s;
   logic [CNT_W-1:0]    count_r;
   logic [ADDR_W-1:0]   base_r;
   logic                is_store_r;
   logic [IDX_W-1:0]    idx_s;
   logic                any_s;

   lsm_prio_enc #(.NUM_REGS(NUM_REGS)) u_prio_enc (
      .vec (rem_mask_r),
      .idx (idx_s),
      .any (any_s)
   );

   // Remaining mask once the current beat's register is retired.
   always_comb begin
      clr_mask_s        = rem_mask_r;
      clr_mask_s[idx_s] = 1'b0;
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Operation context: latched on an accepted start, advanced on each accepted beat.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rem_mask_r <= {NUM_REGS{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         base_r     <= {ADDR_W{1'b0}};
         is_store_r <= 1'b0;
      end else if ((state_r == IDLE) && start) begin
         rem_mask_r <= mask;
         count_r    <= {CNT_W{1'b0}};
         base_r     <= base_addr;
         is_store_r <= is_store;
      end else if ((state_r == XFER) && mem_ready) begin
         rem_mask_r <= clr_mask_s;
         count_r    <= count_r + CNT_W'(1);
      end else begin
         rem_mask_r <= rem_mask_r;
         count_r    <= count_r;
         base_r     <= base_r;
         is_store_r <= is_store_r;
      end
   end

   // Next-state logic; an empty mask skips straight to DONE.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (mask == {NUM_REGS{1'b0}}) begin
                  next_s = DONE;
               end else begin
                  next_s = XFER;
               end
            end else begin
               next_s = IDLE;
            end
         end
         XFER: begin
            if (!any_s) begin
               next_s = DONE;
            end else if (mem_ready && (clr_mask_s == {NUM_REGS{1'b0}})) begin
               next_s = DONE;
            end else begin
               next_s = XFER;
            end
         end
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // Outputs decode from the state so reset clears them immediately.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      rf_raddr  = {IDX_W{1'b0}};
      rf_we     = 1'b0;
      rf_waddr  = {IDX_W{1'b0}};
      rf_wdata  = {DATA_W{1'b0}};
`ifdef LSM_WRITEBACK_EN
      wb_we     = 1'b0;
      wb_addr   = {ADDR_W{1'b0}};
`endif
      case (state_r)
         IDLE: begin
            busy = 1'b0;
         end
         XFER: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            mem_we   = is_store_r;
            mem_addr = base_r + ADDR_W'(count_r);
            if (is_store_r) begin
               rf_raddr  = idx_s;
               mem_wdata = rf_rdata;
            end else begin
               rf_we    = mem_ready;
               rf_waddr = idx_s;
               rf_wdata = mem_rdata;
            end
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
`ifdef LSM_WRITEBACK_EN
            wb_we   = 1'b1;
            wb_addr = base_r + ADDR_W'(count_r);
`endif
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Scoreboard bench for lsm_sequencer: directed operations push expected beats and
// completions; a negedge monitor pops and compares whenever the DUT presents one.
module tb_lsm_sequencer;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        is_store;
   logic [7:0]  mask;
   logic [15:0] base_addr;
   logic        busy;
   logic        done;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic [2:0]  rf_raddr;
   logic [15:0] rf_rdata;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
`ifdef LSM_WRITEBACK_EN
   logic        wb_we;
   logic [15:0] wb_addr;
`endif

   lsm_sequencer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .start     (start),
      .is_store  (is_store),
      .mask      (mask),
      .base_addr (base_addr),
      .busy      (busy),
      .done      (done),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .rf_raddr  (rf_raddr),
      .rf_rdata  (rf_rdata),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata)
`ifdef LSM_WRITEBACK_EN
      ,
      .wb_we     (wb_we),
      .wb_addr   (wb_addr)
`endif
   );

   // Memory returns addr^0xAAAA; register file returns 0x1000+index.
   assign mem_rdata = mem_addr ^ 16'hAAAA;
   assign rf_rdata  = 16'h1000 + {13'd0, rf_raddr};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        is_done;
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
      logic [2:0]  idx;
      int          lat;
      logic [15:0] wb;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   cyc       = 0;
   int   start_cyc = 0;
   int   done_cnt  = 0;
   int   rf_we_cnt = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void push_beat(input logic we, input logic [15:0] addr,
                                     input logic [15:0] data, input logic [2:0] idx);
      exp_t e;
      e.is_done = 1'b0; e.we = we; e.addr = addr; e.data = data; e.idx = idx;
      e.lat = 0; e.wb = 16'h0000;
      exp_q.push_back(e);
   endfunction

   function automatic void push_done(input int lat, input logic [15:0] wb);
      exp_t e;
      e.is_done = 1'b1; e.we = 1'b0; e.addr = 16'h0000; e.data = 16'h0000; e.idx = 3'd0;
      e.lat = lat; e.wb = wb;
      exp_q.push_back(e);
   endfunction

   // Monitor: every accepted beat or done pulse consumes one scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n) begin
            if (rf_we) rf_we_cnt++;
            if ((mem_req && mem_ready) || done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_event", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("event_kind", {31'd0, done}, {31'd0, e.is_done});
                  if (e.is_done) begin
                     check("done_latency", cyc - start_cyc, e.lat);
                     check("busy_in_done", {31'd0, busy}, 32'd1);
`ifdef LSM_WRITEBACK_EN
                     check("wb_we", {31'd0, wb_we}, 32'd1);
                     check("wb_addr", {16'd0, wb_addr}, {16'd0, e.wb});
`endif
                  end else begin
                     check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                     check("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                     if (e.we) begin
                        check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
                        check("rf_raddr", {29'd0, rf_raddr}, {29'd0, e.idx});
                        check("rf_we_on_store", {31'd0, rf_we}, 32'd0);
                     end else begin
                        check("rf_we", {31'd0, rf_we}, 32'd1);
                        check("rf_waddr", {29'd0, rf_waddr}, {29'd0, e.idx});
                        check("rf_wdata", {16'd0, rf_wdata}, {16'd0, e.data});
                     end
                  end
               end
               if (done) done_cnt++;
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
      check({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
      check({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
      check({tag, "_rf_waddr"}, {29'd0, rf_waddr}, 32'd0);
      check({tag, "_rf_raddr"}, {29'd0, rf_raddr}, 32'd0);
      check({tag, "_rf_wdata"}, {16'd0, rf_wdata}, 32'd0);
`ifdef LSM_WRITEBACK_EN
      check({tag, "_wb_we"}, {31'd0, wb_we}, 32'd0);
      check({tag, "_wb_addr"}, {16'd0, wb_addr}, 32'd0);
`endif
   endtask

   // One-cycle start pulse; afterwards the inputs are scrambled, which the DUT must ignore.
   task automatic launch(input logic st, input logic [7:0] m, input logic [15:0] b);
      @(posedge clock); #1;
      is_store  = st;
      mask      = m;
      base_addr = b;
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clock); #1;
      start     = 1'b0;
      is_store  = ~st;
      mask      = 8'hFF;
      base_addr = 16'hDEAD;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n;
      n = 0;
      while ((done_cnt == d0) && (n < budget)) begin
         @(posedge clock);
         n++;
      end
      check("done_timeout", {31'd0, (done_cnt == d0)}, 32'd0);
   endtask

   initial begin
      int d0;
      int w0;
      reset_n   = 1'b0;
      start     = 1'b0;
      is_store  = 1'b0;
      mask      = 8'h00;
      base_addr = 16'h0000;
      mem_ready = 1'b1;
      #3;
      check_all_zero("reset");
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // Load, sparse mask.
      w0 = rf_we_cnt; d0 = done_cnt;
      push_beat(1'b0, 16'h0100, 16'hABAA, 3'd0);
      push_beat(1'b0, 16'h0101, 16'hABAB, 3'd2);
      push_beat(1'b0, 16'h0102, 16'hABA8, 3'd5);
      push_beat(1'b0, 16'h0103, 16'hABA9, 3'd7);
      push_done(5, 16'h0104);
      launch(1'b0, 8'b1010_0101, 16'h0100);
      wait_done(d0, 30);
      check("load_rf_we_pulses", rf_we_cnt - w0, 32'd4);

      // Store, two registers.
      w0 = rf_we_cnt; d0 = done_cnt;
      push_beat(1'b1, 16'h0200, 16'h1001, 3'd1);
      push_beat(1'b1, 16'h0201, 16'h1002, 3'd2);
      push_done(3, 16'h0202);
      launch(1'b1, 8'b0000_0110, 16'h0200);
      wait_done(d0, 30);
      check("store_rf_we_pulses", rf_we_cnt - w0, 32'd0);

      // Load with a 3-cycle stall on the second beat.
      w0 = rf_we_cnt; d0 = done_cnt;
      push_beat(1'b0, 16'h0300, 16'hA9AA, 3'd1);
      push_beat(1'b0, 16'h0301, 16'hA9AB, 3'd3);
      push_beat(1'b0, 16'h0302, 16'hA9A8, 3'd4);
      push_done(7, 16'h0303);
      launch(1'b0, 8'b0001_1010, 16'h0300);
      @(posedge clock); #1;
      mem_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clock);
         check("stall_mem_addr", {16'd0, mem_addr}, 32'h0301);
         check("stall_rf_waddr", {29'd0, rf_waddr}, 32'd3);
         check("stall_rf_we", {31'd0, rf_we}, 32'd0);
         @(posedge clock); #1;
      end
      mem_ready = 1'b1;
      wait_done(d0, 30);
      check("stall_rf_we_pulses", rf_we_cnt - w0, 32'd3);

      // Empty mask: straight to DONE.
      d0 = done_cnt;
      push_done(1, 16'h0600);
      launch(1'b0, 8'h00, 16'h0600);
      wait_done(d0, 10);

      // Full mask across the address wrap.
      w0 = rf_we_cnt; d0 = done_cnt;
      push_beat(1'b0, 16'hFFFE, 16'h5554, 3'd0);
      push_beat(1'b0, 16'hFFFF, 16'h5555, 3'd1);
      push_beat(1'b0, 16'h0000, 16'hAAAA, 3'd2);
      push_beat(1'b0, 16'h0001, 16'hAAAB, 3'd3);
      push_beat(1'b0, 16'h0002, 16'hAAA8, 3'd4);
      push_beat(1'b0, 16'h0003, 16'hAAA9, 3'd5);
      push_beat(1'b0, 16'h0004, 16'hAAAE, 3'd6);
      push_beat(1'b0, 16'h0005, 16'hAAAF, 3'd7);
      push_done(9, 16'h0006);
      launch(1'b0, 8'hFF, 16'hFFFE);
      wait_done(d0, 30);
      check("full_rf_we_pulses", rf_we_cnt - w0, 32'd8);

      // Reset in the middle of the second beat abandons the operation.
      w0 = rf_we_cnt; d0 = done_cnt;
      push_beat(1'b0, 16'h0400, 16'hAEAA, 3'd0);
      launch(1'b0, 8'b0000_0111, 16'h0400);
      @(posedge clock); #1;
      check("pre_reset_mem_addr", {16'd0, mem_addr}, 32'h0401);
      #1 reset_n = 1'b0;
      #1;
      check_all_zero("abort");
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("abort_no_done", done_cnt - d0, 32'd0);
      check("abort_rf_we_pulses", rf_we_cnt - w0, 32'd1);
      check("abort_idle_busy", {31'd0, busy}, 32'd0);

      // Fresh run after reset; start held high mid-operation and in DONE is ignored.
      w0 = rf_we_cnt; d0 = done_cnt;
      push_beat(1'b0, 16'h0500, 16'hAFAA, 3'd0);
      push_beat(1'b0, 16'h0501, 16'hAFAB, 3'd1);
      push_done(3, 16'h0502);
      launch(1'b0, 8'b0000_0011, 16'h0500);
      start     = 1'b1;
      is_store  = 1'b1;
      mask      = 8'hFF;
      base_addr = 16'h0900;
      repeat (3) @(posedge clock);
      #1 start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("midstart_done_count", done_cnt - d0, 32'd1);
      check("midstart_rf_we_pulses", rf_we_cnt - w0, 32'd2);
      check("midstart_idle_busy", {31'd0, busy}, 32'd0);
      check("midstart_idle_mem_req", {31'd0, mem_req}, 32'd0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Parametrised load/store-multiple sequencer; successor to the fixed 8-register, load-only LM unit.
- Walks a register mask from lowest to highest set bit and issues one memory beat per selected register at consecutive addresses from a base.
- Loads write the register file; stores read the register file.
- Sits between decode/execute and the data-memory port; stalls the pipeline via busy.

Parameters:
- NUM_REGS, 8, number of architectural registers (mask width, >=2).
- DATA_W, 16, register and memory data width.
- ADDR_W, 16, memory address width.
- localparam IDX_W = $clog2(NUM_REGS), register index width.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- is_store  input  1  1 = store-multiple, 0 = load-multiple; sampled with start.
- mask  input  NUM_REGS  register select; bit i selects register i.
- base_addr  input  ADDR_W  address of the first beat.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- mem_req  output  1  beat request.
- mem_we  output  1  1 = write beat.
- mem_addr  output  ADDR_W  beat address.
- mem_wdata  output  DATA_W  store data.
- mem_ready  input  1  beat accepted this cycle; on loads, mem_rdata is valid in the same cycle.
- mem_rdata  input  DATA_W  load data.
- rf_raddr  output  IDX_W  register-file read index (stores).
- rf_rdata  input  DATA_W  combinational register-file read data.
- rf_we  output  1  register-file write strobe.
- rf_waddr  output  IDX_W  write index.
- rf_wdata  output  DATA_W  write data.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; remaining mask, count, base and direction registers cleared.
  - All outputs 0.
  - An in-flight beat is abandoned and no rf_we follows.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - start=1 with mask!=0: latch mask, base_addr and is_store; count=0; go to XFER.
  - start=1 with mask==0: go directly to DONE; no memory beats.
  - start=0: stay in IDLE.
- XFER:
  - idx = lowest set bit of the remaining mask (combinational).
  - mem_req=1; mem_we=latched is_store; mem_addr = base + count, wrapping modulo 2^ADDR_W.
  - Store: rf_raddr=idx; mem_wdata=rf_rdata.
  - Load: rf_we = mem_ready; rf_waddr=idx; rf_wdata=mem_rdata. The write occurs in the same cycle the beat is accepted.
  - Beat accepted when mem_req and mem_ready are both 1: clear bit idx, count+1.
  - If the remaining mask becomes 0, go to DONE; otherwise stay in XFER.
  - mem_ready=0: hold all beat outputs stable; no state change.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then return to IDLE.
  - start during DONE is ignored.
- start, mask and is_store changes outside IDLE are ignored; the latched copies govern the operation.
- Latency: N selected registers take N beats plus 1 DONE cycle, plus any mem_ready stalls. The first mem_req appears the cycle after start.
- Outputs not listed as active in a state are 0. rf_raddr and rf_waddr are 0 outside XFER.
- Full mask (all NUM_REGS bits set): NUM_REGS beats, highest index last.

Optional Feature:
- Macro LSM_WRITEBACK_EN.
- Defined: adds ports wb_we (output, 1) and wb_addr (output, ADDR_W).
  - In the DONE cycle, wb_we=1 and wb_addr = base + number of beats, wrapping; this is the base-register writeback value.
  - For mask==0, wb_addr = base.
  - wb_we and wb_addr reset to 0 and are 0 outside DONE.
- Not defined: no such ports; base writeback is the caller's job.

Decomposition:
- Package lsm_pkg holds:
  - the state enum (IDLE, XFER, DONE);
  - default NUM_REGS, DATA_W and ADDR_W constants;
  - a function computing the popcount width.
- Sub-module lsm_prio_enc: parametrised lowest-set-bit encoder with inputs vec[NUM_REGS] and outputs idx[IDX_W] and any.

Test Plan:
- Load, mask=8'b1010_0101, base=0x0100, mem_ready always 1, mem_rdata=addr^0xAAAA → rf writes r0@0x0100, r2@0x0101, r5@0x0102, r7@0x0103; done 5 cycles after start.
- Store, mask=8'b0000_0110, base=0x0200, rf_rdata=0x1000+rf_raddr → mem writes 0x1001@0x0200, 0x1002@0x0201; mem_we=1 on both beats.
- mem_ready held low for 3 cycles on the 2nd beat of a 3-bit load → mem_addr and rf_waddr stable through the stall; only 3 rf_we pulses total.
- mask=0 with start → no mem_req; done one cycle after start. With LSM_WRITEBACK_EN, wb_addr=base.
- Full mask, base=0xFFFE → addresses 0xFFFE, 0xFFFF, 0x0000…0x0005 (wrap). With LSM_WRITEBACK_EN, wb_addr=0x0006.
- reset_n asserted during the 2nd beat → all outputs 0 immediately, no done. A fresh start after release runs normally; a start pulsed mid-operation is ignored.
